// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central sequencer for the five-stage RV32 pipeline (IF, ID, EX, MEM, WB).
//   Detects load-use hazards between the ID-stage register reads and a load in
//   EX, accepts EX-stage redirects and data-memory wait requests, and drives
//   the pipeline register stall/flush controls. It also produces the EX-stage
//   operand forwarding selects and keeps stall/flush performance counters.
//   Pure control: no datapath passes through this block.
//
// Ports
//   clk, rst_n                 core clock, asynchronous active-low reset
//   id_rs1/2_addr, _used       source registers read by the instruction in ID
//   ex_rs1/2_addr              source registers of the instruction in EX
//   ex_rd_addr, ex_wb_en,
//   ex_is_load, ex_redirect    destination / kind / redirect of EX instruction
//   mem_rd_addr, mem_wb_en     destination of the instruction in MEM
//   wb_rd_addr, wb_wb_en       destination of the instruction in WB
//   mem_busy                   data access pending; freeze the pipeline
//   pc_stall, if_id_stall      hold PC / IF_ID
//   if_id_flush, id_ex_flush   load a NOP into IF_ID / ID_EX
//   freeze                     hold ID_EX, EX_MEM, MEM_WB
//   fwd_a_sel, fwd_b_sel       00 regfile, 01 EX_MEM, 10 MEM_WB
//   state_o                    current sequencer state
//   stall_cnt, flush_cnt       cycles stalled / redirects accepted
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int REG_AW           = 5,
   parameter int CNT_W            = 32,
   parameter int REDIRECT_BUBBLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_rs1_addr,
   input  logic [REG_AW-1:0] ex_rs2_addr,
   input  logic [REG_AW-1:0] ex_rd_addr,
   input  logic              ex_wb_en,
   input  logic              ex_is_load,
   input  logic              ex_redirect,
   input  logic [REG_AW-1:0] mem_rd_addr,
   input  logic              mem_wb_en,
   input  logic [REG_AW-1:0] wb_rd_addr,
   input  logic              wb_wb_en,
   input  logic              mem_busy,
   output logic              pc_stall,
   output logic              if_id_stall,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              freeze,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic [1:0]        state_o,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_LOAD_USE = 2'd1,
      S_REDIRECT = 2'd2,
      S_MEM_WAIT = 2'd3
   } state_t;

   localparam logic [1:0] BUB_INIT =
      (REDIRECT_BUBBLES > 0) ? 2'(REDIRECT_BUBBLES - 1) : 2'd0;

   state_t           r_state, r_resume;
   logic [1:0]       r_bub_cnt;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

   state_t     w_next_state, w_next_resume, w_eff_state;
   logic [1:0] w_next_bub;
   logic       w_hz, w_redirect_acc;
   logic       w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_flush, w_freeze;
   logic [1:0] w_fwd_a, w_fwd_b;

   // Load in EX whose destination is read by the instruction in ID.
   assign w_hz = ex_is_load & ex_wb_en & (ex_rd_addr != '0) &
                 ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                  (id_rs2_used & (id_rs2_addr == ex_rd_addr)));

   // On the cycle MEM_WAIT is released, behave exactly as the interrupted state.
   assign w_eff_state = (r_state == S_MEM_WAIT) ? r_resume : r_state;

   // NOTE: every signal written here gets a default first, so no path through
   // the block leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_next_state   = r_state;
      w_next_resume  = r_resume;
      w_next_bub     = r_bub_cnt;
      w_redirect_acc = 1'b0;
      w_pc_stall     = 1'b0;
      w_if_id_stall  = 1'b0;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_freeze       = 1'b0;

      if (mem_busy) begin
         w_freeze      = 1'b1;
         w_pc_stall    = 1'b1;
         w_if_id_stall = 1'b1;
         w_next_state  = S_MEM_WAIT;
         // Only remember the state we came from, not MEM_WAIT itself.
         if (r_state != S_MEM_WAIT) w_next_resume = r_state;
      end else if (ex_redirect) begin
         w_redirect_acc = 1'b1;
         w_if_id_flush  = 1'b1;
         w_id_ex_flush  = 1'b1;
         if (REDIRECT_BUBBLES > 0) begin
            w_next_state = S_REDIRECT;
            w_next_bub   = BUB_INIT;
         end else begin
            w_next_state = S_RUN;
         end
      end else begin
         case (w_eff_state)
            S_RUN, S_LOAD_USE: begin
               if (w_hz) begin
                  w_pc_stall    = 1'b1;
                  w_if_id_stall = 1'b1;
                  w_id_ex_flush = 1'b1;
                  w_next_state  = S_LOAD_USE;
               end else begin
                  w_next_state  = S_RUN;
               end
            end
            S_REDIRECT: begin
               // Fetches still in flight from the wrong path are squashed,
               // including on the final (counter == 0) cycle.
               w_if_id_flush = 1'b1;
               if (r_bub_cnt == 2'd0) begin
                  w_next_state = S_RUN;
               end else begin
                  w_next_bub   = r_bub_cnt - 2'd1;
                  w_next_state = S_REDIRECT;
               end
            end
            default: w_next_state = S_RUN;
         endcase
      end
   end

   // EX_MEM holds the youngest producer, so it is checked first.
   always_comb begin
      w_fwd_a = 2'b00;
      if (mem_wb_en && mem_rd_addr != '0 && mem_rd_addr == ex_rs1_addr)
         w_fwd_a = 2'b01;
      else if (wb_wb_en && wb_rd_addr != '0 && wb_rd_addr == ex_rs1_addr)
         w_fwd_a = 2'b10;

      w_fwd_b = 2'b00;
      if (mem_wb_en && mem_rd_addr != '0 && mem_rd_addr == ex_rs2_addr)
         w_fwd_b = 2'b01;
      else if (wb_wb_en && wb_rd_addr != '0 && wb_rd_addr == ex_rs2_addr)
         w_fwd_b = 2'b10;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_RUN;
         r_resume    <= S_RUN;
         r_bub_cnt   <= 2'd0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_next_state;
         r_resume    <= w_next_resume;
         r_bub_cnt   <= w_next_bub;
         r_stall_cnt <= r_stall_cnt + CNT_W'(w_pc_stall);
         r_flush_cnt <= r_flush_cnt + CNT_W'(w_redirect_acc);
      end
   end

   // Controls are combinational, so they are gated to stay quiet during reset.
   assign pc_stall    = rst_n & w_pc_stall;
   assign if_id_stall = rst_n & w_if_id_stall;
   assign if_id_flush = rst_n & w_if_id_flush;
   assign id_ex_flush = rst_n & w_id_ex_flush;
   assign freeze      = rst_n & w_freeze;
   assign fwd_a_sel   = rst_n ? w_fwd_a : 2'b00;
   assign fwd_b_sel   = rst_n ? w_fwd_b : 2'b00;
   assign state_o     = r_state;
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;

endmodule
